// File: rtl/alu_result_fifo_pkg.sv
// Shared ALU definitions: op encodings, result width and the packed layout of a buffered entry.
// An entry is {op[7:6], c[5:2], co_m[1], z[0]}; flags are fixed at capture time.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] ALU_OP_ADD = 2'd0;
    localparam logic [1:0] ALU_OP_SUB = 2'd1;
    localparam logic [1:0] ALU_OP_AND = 2'd2;
    localparam logic [1:0] ALU_OP_OR  = 2'd3;

    localparam int ENTRY_Z_BIT  = 0;
    localparam int ENTRY_CO_BIT = 1;
    localparam int ENTRY_C_LSB  = 2;
    localparam int ENTRY_OP_LSB = 6;
    localparam int ENTRY_W      = 8;

    // Carry is meaningless for logic ops, so it is forced low for AND/OR.
    function automatic logic [1:0] calc_flags(input logic [1:0] op,
                                              input logic [ALU_W-1:0] c,
                                              input logic co);
        logic co_m;
        logic z;
        co_m = co & (op != ALU_OP_AND) & (op != ALU_OP_OR);
        z    = (c == '0);
        return {co_m, z};
    endfunction

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [1:0] op,
                                                      input logic [ALU_W-1:0] c,
                                                      input logic co);
        return {op, c, calc_flags(op, c, co)};
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake bundle around the ALU result buffer.
// master drives pushes and pops; slave is the buffer itself.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [ALU_W-1:0] in_c;
    logic             in_co;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_op;
    logic [ALU_W-1:0] out_c;
    logic             out_co;
    logic             out_zero;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_op, in_c, in_co, out_ready,
        input  in_ready, out_valid, out_op, out_c, out_co, out_zero, count
    );

    modport slave (
        input  in_valid, in_op, in_c, in_co, out_ready,
        output in_ready, out_valid, out_op, out_c, out_co, out_zero, count
    );

endinterface

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read, no reset.
// Contents after reset are don't-care; the owner masks reads while empty.
module sync_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: captures {op, c, carry, zero} on push, 1-cycle latency, in_ready drops only when full.
// Define ALU_RESULT_FIFO_BYPASS_EN to let an entry pass straight through when the FIFO is empty.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_vld;
    logic               push;
    logic               wr_en;
    logic               pop_mem;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        in_entry    = make_entry(bus.in_op, bus.in_c, bus.in_co);
        bus.in_ready = (count_q != CW'(DEPTH));
        push        = bus.in_valid & bus.in_ready;
        pop_mem     = (count_q != '0) & bus.out_ready;
`ifdef ALU_RESULT_FIFO_BYPASS_EN
        // Empty FIFO: present the incoming entry directly; skip the write if it is consumed now.
        head_vld    = (count_q != '0) | bus.in_valid;
        head_entry  = (count_q == '0) ? in_entry : rd_entry;
        wr_en       = push & ~((count_q == '0) & bus.out_ready);
`else
        head_vld    = (count_q != '0);
        head_entry  = rd_entry;
        wr_en       = push;
`endif
    end

    always_comb begin
        bus.out_valid = head_vld;
        bus.out_op    = head_vld ? head_entry[ENTRY_OP_LSB +: 2]     : '0;
        bus.out_c     = head_vld ? head_entry[ENTRY_C_LSB +: ALU_W]  : '0;
        bus.out_co    = head_vld & head_entry[ENTRY_CO_BIT];
        bus.out_zero  = head_vld & head_entry[ENTRY_Z_BIT];
        bus.count     = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_en   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_mem ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop_mem})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, flag capture, full, concurrent, empty edge and hold.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    alu_result_fifo_if #(.DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] c, input logic co);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_c     = c;
        bus.in_co    = co;
    endtask

    task automatic test_reset();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        vecs++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_init count=%0d out_valid=%0b in_ready=%0b want 0/0/1", bus.count, bus.out_valid, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, ALU_OP_ADD, 4'hA, 1'b0); tick();
        drive(1'b1, ALU_OP_ADD, 4'hB, 1'b0); tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.count !== 3'd2 || bus.out_c !== 4'hA) begin
            errs++; $display("FAIL reset_pre count=%0d out_c=%h want 2/a", bus.count, bus.out_c);
        end
        #2 rst = 1'b1;
        #1;
        vecs++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_c !== 4'h0) begin
            errs++; $display("FAIL reset_async count=%0d out_valid=%0b in_ready=%0b out_c=%h want 0/0/1/0",
                             bus.count, bus.out_valid, bus.in_ready, bus.out_c);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, ALU_OP_OR, 4'h3, 1'b0); tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.count !== 3'd1 || bus.out_c !== 4'h3 || bus.out_op !== ALU_OP_OR) begin
            errs++; $display("FAIL reset_after count=%0d out_c=%h out_op=%0d want 1/3/3", bus.count, bus.out_c, bus.out_op);
        end
        bus.out_ready = 1'b1; tick();
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_drain count=%0d out_valid=%0b want 0/0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_flags();
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_OP_ADD, 4'h0, 1'b1); tick();
        drive(1'b1, ALU_OP_OR,  4'h0, 1'b1); tick();
        drive(1'b1, ALU_OP_SUB, 4'h5, 1'b0); tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.count !== 3'd3) begin
            errs++; $display("FAIL flags_count got %0d want 3", bus.count);
        end
        vecs++; if ({bus.out_op, bus.out_c, bus.out_co, bus.out_zero} !== {2'd0, 4'h0, 1'b1, 1'b1}) begin
            errs++; $display("FAIL flags_head0 got op=%0d c=%h co=%0b z=%0b want 0/0/1/1", bus.out_op, bus.out_c, bus.out_co, bus.out_zero);
        end
        bus.out_ready = 1'b1; tick();
        vecs++; if ({bus.out_op, bus.out_c, bus.out_co, bus.out_zero} !== {2'd3, 4'h0, 1'b0, 1'b1}) begin
            errs++; $display("FAIL flags_head1 got op=%0d c=%h co=%0b z=%0b want 3/0/0/1", bus.out_op, bus.out_c, bus.out_co, bus.out_zero);
        end
        tick();
        vecs++; if ({bus.out_op, bus.out_c, bus.out_co, bus.out_zero} !== {2'd1, 4'h5, 1'b0, 1'b0}) begin
            errs++; $display("FAIL flags_head2 got op=%0d c=%h co=%0b z=%0b want 1/5/0/0", bus.out_op, bus.out_c, bus.out_co, bus.out_zero);
        end
        tick();
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin
            errs++; $display("FAIL flags_drain count got %0d want 0", bus.count);
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, ALU_OP_SUB, 4'(i), 1'b1); tick();
        end
        vecs++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errs++; $display("FAIL full_count count=%0d in_ready=%0b want 4/0", bus.count, bus.in_ready);
        end
        drive(1'b1, ALU_OP_SUB, 4'h5, 1'b1); tick();
        vecs++; if (bus.count !== 3'd4 || bus.out_c !== 4'h1) begin
            errs++; $display("FAIL full_hold count=%0d out_c=%h want 4/1", bus.count, bus.out_c);
        end
        bus.out_ready = 1'b1; tick();
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_c !== 4'h2) begin
            errs++; $display("FAIL full_pop count=%0d in_ready=%0b out_c=%h want 3/1/2", bus.count, bus.in_ready, bus.out_c);
        end
        tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.count !== 3'd4) begin
            errs++; $display("FAIL full_refill count got %0d want 4", bus.count);
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            vecs++; if (bus.out_c !== 4'(k) || bus.out_co !== 1'b1) begin
                errs++; $display("FAIL full_order out_c=%h out_co=%0b want %h/1", bus.out_c, bus.out_co, 4'(k));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin
            errs++; $display("FAIL full_drain count got %0d want 0", bus.count);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_OP_AND, 4'h0, 1'b1); tick();
        drive(1'b1, ALU_OP_AND, 4'h1, 1'b1); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ALU_OP_AND, 4'(i + 2), 1'b1);
            bus.out_ready = 1'b1;
            vecs++; if (bus.out_c !== 4'(i) || bus.out_co !== 1'b0 || bus.out_zero !== (i == 0)) begin
                errs++; $display("FAIL b2b_head i=%0d out_c=%h co=%0b z=%0b want %h/0/%0b", i, bus.out_c, bus.out_co, bus.out_zero, 4'(i), (i == 0));
            end
            tick();
            vecs++; if (bus.count !== 3'd2) begin
                errs++; $display("FAIL b2b_count i=%0d got %0d want 2", i, bus.count);
            end
        end
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.out_c !== 4'hA) begin
            errs++; $display("FAIL b2b_tail0 got %h want a", bus.out_c);
        end
        tick();
        vecs++; if (bus.out_c !== 4'hB) begin
            errs++; $display("FAIL b2b_tail1 got %h want b", bus.out_c);
        end
        tick();
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin
            errs++; $display("FAIL b2b_drain count got %0d want 0", bus.count);
        end
    endtask

    task automatic test_empty_edge();
        bus.out_ready = 1'b1;
        drive(1'b1, ALU_OP_ADD, 4'h9, 1'b0);
        #1;
`ifdef ALU_RESULT_FIFO_BYPASS_EN
        vecs++; if (bus.out_valid !== 1'b1 || bus.out_c !== 4'h9) begin
            errs++; $display("FAIL empty_same out_valid=%0b out_c=%h want 1/9", bus.out_valid, bus.out_c);
        end
        tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL empty_bypass count=%0d out_valid=%0b want 0/0", bus.count, bus.out_valid);
        end
`else
        vecs++; if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL empty_same out_valid got %0b want 0", bus.out_valid);
        end
        tick();
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        vecs++; if (bus.out_valid !== 1'b1 || bus.out_c !== 4'h9 || bus.count !== 3'd1) begin
            errs++; $display("FAIL empty_next out_valid=%0b out_c=%h count=%0d want 1/9/1", bus.out_valid, bus.out_c, bus.count);
        end
        tick();
        vecs++; if (bus.count !== 3'd0) begin
            errs++; $display("FAIL empty_drain count got %0d want 0", bus.count);
        end
`endif
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_OP_SUB, 4'h7, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ALU_OP_OR, 4'(8 + i), 1'b0); tick();
            vecs++; if ({bus.out_op, bus.out_c, bus.out_co, bus.out_zero} !== {2'd1, 4'h7, 1'b1, 1'b0}) begin
                errs++; $display("FAIL hold_head cyc=%0d got op=%0d c=%h co=%0b z=%0b want 1/7/1/0",
                                 i, bus.out_op, bus.out_c, bus.out_co, bus.out_zero);
            end
        end
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin
            errs++; $display("FAIL hold_drain count got %0d want 0", bus.count);
        end
    endtask

    initial begin
        drive(1'b0, ALU_OP_ADD, 4'h0, 1'b0);
        bus.out_ready = 1'b0;
        test_reset();
        test_flags();
        test_full();
        test_back_to_back();
        test_empty_edge();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
